// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Issues one host command to one of four registered ALU units and
//            returns the captured result over a valid/ready result port.
// Revision : 1.0
// ============================================================================
module alu_cmd_sequencer #(
    parameter int Width = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [Width-1:0] CMD_A,
    input  logic [Width-1:0] CMD_B,
    input  logic [3:0]       CMD_OP,
    output logic [Width-1:0] A,
    output logic [Width-1:0] B,
    output logic [1:0]       ALU_FUN,
    output logic             Arith_Enable,
    output logic             Logic_Enable,
    output logic             CMP_Enable,
    output logic             Shift_Enable,
    input  logic [Width-1:0] Arith_OUT,
    input  logic [Width-1:0] Logic_OUT,
    input  logic [Width-1:0] CMP_OUT,
    input  logic [Width-1:0] Shift_OUT,
    input  logic             Arith_Flag,
    input  logic             Logic_Flag,
    input  logic             CMP_Flag,
    input  logic             Shift_Flag,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [Width-1:0] RES_DATA,
    output logic [1:0]       RES_UNIT,
    output logic             RES_ERR,
    output logic [7:0]       OP_COUNT
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [Width-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [Width-1:0]   res_data_q, res_data_d;
    logic [1:0]         res_unit_q, res_unit_d;
    logic               res_err_q, res_err_d;
    logic [7:0]         count_q, count_d;
    logic [Width-1:0]   w_sel_data;
    logic               w_sel_flag;

    // Only the unit that was issued contributes to the captured result.
    always_comb begin
        w_sel_data = '0;
        w_sel_flag = 1'b0;
        case (op_q[3:2])
            2'b00:   begin w_sel_data = Arith_OUT; w_sel_flag = Arith_Flag; end
            2'b01:   begin w_sel_data = Logic_OUT; w_sel_flag = Logic_Flag; end
            2'b10:   begin w_sel_data = CMP_OUT;   w_sel_flag = CMP_Flag;   end
            default: begin w_sel_data = Shift_OUT; w_sel_flag = Shift_Flag; end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        res_data_d = res_data_q;
        res_unit_d = res_unit_q;
        res_err_d  = res_err_q;
        count_d    = count_q;
        case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    a_d     = CMD_A;
                    b_d     = CMD_B;
                    op_d    = CMD_OP;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                res_data_d = w_sel_data;
                res_unit_d = op_q[3:2];
                res_err_d  = ~w_sel_flag;
                state_d    = RESP;
            end
            RESP: begin
                if (RES_READY) begin
                    count_d = count_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_data_q <= '0;
            res_unit_q <= '0;
            res_err_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_data_q <= res_data_d;
            res_unit_q <= res_unit_d;
            res_err_q  <= res_err_d;
            count_q    <= count_d;
        end
    end

    // Operand registers only load on accept, so A/B/ALU_FUN hold the last
    // issued command everywhere outside ISSUE.
    assign A            = a_q;
    assign B            = b_q;
    assign ALU_FUN      = op_q[1:0];
    assign Arith_Enable = (state_q == ISSUE) && (op_q[3:2] == 2'b00);
    assign Logic_Enable = (state_q == ISSUE) && (op_q[3:2] == 2'b01);
    assign CMP_Enable   = (state_q == ISSUE) && (op_q[3:2] == 2'b10);
    assign Shift_Enable = (state_q == ISSUE) && (op_q[3:2] == 2'b11);
    assign CMD_READY    = (state_q == IDLE);
    assign RES_VALID    = (state_q == RESP);
    assign RES_DATA     = res_data_q;
    assign RES_UNIT     = res_unit_q;
    assign RES_ERR      = res_err_q;
    assign OP_COUNT     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Brief    : Self-checking bench with behavioural ALU unit models.
// Revision : 1.0
// ============================================================================
module tb_alu_cmd_sequencer;

    logic        CLK, RST;
    logic        CMD_VALID, CMD_READY;
    logic [15:0] CMD_A, CMD_B, A, B;
    logic [3:0]  CMD_OP;
    logic [1:0]  ALU_FUN;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic [15:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
    logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
    logic        RES_VALID, RES_READY, RES_ERR;
    logic [15:0] RES_DATA;
    logic [1:0]  RES_UNIT;
    logic [7:0]  OP_COUNT;

    alu_cmd_sequencer #(.Width(16)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_OP(CMD_OP),
        .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT),
        .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
        .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_DATA(RES_DATA), .RES_UNIT(RES_UNIT), .RES_ERR(RES_ERR),
        .OP_COUNT(OP_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;
    int exp_count = 0;
    bit flag_ok  = 1'b1;

    always @(posedge CLK) cyc <= cyc + 1;

    // Unit function as seen by the host: what each unit computes for a code.
    function automatic logic [15:0] unit_fn(input logic [1:0] u, input logic [1:0] f,
                                            input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = a * b;
        case (u)
            2'b00: case (f)
                2'd0: return a + b;
                2'd1: return a - b;
                2'd2: return p[15:0];
                default: return (b == 16'd0) ? 16'hFFFF : a / b;
            endcase
            2'b01: case (f)
                2'd0: return a & b;
                2'd1: return a | b;
                2'd2: return ~(a & b);
                default: return ~(a | b);
            endcase
            2'b10: case (f)
                2'd0: return (a == b) ? 16'd1 : 16'd0;
                2'd1: return (a > b)  ? 16'd2 : 16'd0;
                2'd2: return (a < b)  ? 16'd3 : 16'd0;
                default: return 16'd0;
            endcase
            default: case (f)
                2'd0: return a >> 1;
                2'd1: return a << 1;
                2'd2: return b >> 1;
                default: return b << 1;
            endcase
        endcase
    endfunction

    // Registered unit models: a disabled unit registers zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Arith_OUT <= '0; Logic_OUT <= '0; CMP_OUT <= '0; Shift_OUT <= '0;
            Arith_Flag <= 1'b0; Logic_Flag <= 1'b0; CMP_Flag <= 1'b0; Shift_Flag <= 1'b0;
        end else begin
            Arith_OUT  <= Arith_Enable ? unit_fn(2'b00, ALU_FUN, A, B) : 16'd0;
            Logic_OUT  <= Logic_Enable ? unit_fn(2'b01, ALU_FUN, A, B) : 16'd0;
            CMP_OUT    <= CMP_Enable   ? unit_fn(2'b10, ALU_FUN, A, B) : 16'd0;
            Shift_OUT  <= Shift_Enable ? unit_fn(2'b11, ALU_FUN, A, B) : 16'd0;
            Arith_Flag <= Arith_Enable & flag_ok;
            Logic_Flag <= Logic_Enable & flag_ok;
            CMP_Flag   <= CMP_Enable   & flag_ok;
            Shift_Flag <= Shift_Enable & flag_ok;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] enables();
        return {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
    endfunction

    always @(negedge CLK) check("enable_at_most_one", ($countones(enables()) <= 1), 1);

    // One full transaction, checked cycle by cycle. Called at a negedge.
    task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input bit fl, input logic [15:0] exp_d, input int hold,
                           input bit early, input bit chk_gap);
        int waited;
        flag_ok   = fl;
        CMD_OP    = op;
        CMD_A     = a;
        CMD_B     = b;
        CMD_VALID = 1'b1;
        RES_READY = early;
        waited = 0;
        while (!CMD_READY && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        check("accept_ready", CMD_READY, 1);
        if (chk_gap) check("accept_gap", cyc - last_acc, 4);
        last_acc = cyc;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        check("issue_enable", enables(), 4'b0001 << op[3:2]);
        check("issue_a", A, a);
        check("issue_b", B, b);
        check("issue_fun", ALU_FUN, op[1:0]);
        check("issue_cmd_ready", CMD_READY, 0);
        check("issue_res_valid", RES_VALID, 0);
        @(negedge CLK);
        check("capture_enable", enables(), 0);
        check("capture_res_valid", RES_VALID, 0);
        @(negedge CLK);
        check("resp_valid", RES_VALID, 1);
        check("resp_data", RES_DATA, exp_d);
        check("resp_unit", RES_UNIT, op[3:2]);
        check("resp_err", RES_ERR, !fl);
        check("resp_cmd_ready", CMD_READY, 0);
        if (hold > 0) RES_READY = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                CMD_VALID = 1'b1;
                CMD_OP    = 4'b0001;
                CMD_A     = ~a;
            end
            @(negedge CLK);
            CMD_VALID = 1'b0;
            check("hold_valid", RES_VALID, 1);
            check("hold_data", RES_DATA, exp_d);
            check("hold_cmd_ready", CMD_READY, 0);
            check("hold_enable", enables(), 0);
            check("hold_a", A, a);
        end
        RES_READY = 1'b1;
        exp_count = (exp_count + 1) % 256;
        @(negedge CLK);
        check("done_valid", RES_VALID, 0);
        check("done_cmd_ready", CMD_READY, 1);
        check("done_count", OP_COUNT, exp_count);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        bit          fl;
        logic [15:0] exp_d;
        int          hold;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'b0100, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 0};
        vecs[1]  = '{4'b0111, 16'h0000, 16'h00FF, 1'b1, 16'hFF00, 5};
        vecs[2]  = '{4'b0101, 16'h1200, 16'h0034, 1'b1, 16'h1234, 0};
        vecs[3]  = '{4'b0110, 16'hFFFF, 16'h00FF, 1'b1, 16'hFF00, 1};
        vecs[4]  = '{4'b0000, 16'h0001, 16'hFFFF, 1'b1, 16'h0000, 0};
        vecs[5]  = '{4'b0001, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 2};
        vecs[6]  = '{4'b0010, 16'h0100, 16'h0003, 1'b1, 16'h0300, 0};
        vecs[7]  = '{4'b1000, 16'h1234, 16'h1234, 1'b1, 16'h0001, 0};
        vecs[8]  = '{4'b1001, 16'h0002, 16'h0001, 1'b1, 16'h0002, 0};
        vecs[9]  = '{4'b1010, 16'h0002, 16'h0001, 1'b1, 16'h0000, 0};
        vecs[10] = '{4'b1100, 16'h8000, 16'h5555, 1'b1, 16'h4000, 0};
        vecs[11] = '{4'b1101, 16'h8001, 16'h0000, 1'b1, 16'h0002, 0};
        vecs[12] = '{4'b1100, 16'h0004, 16'h0000, 1'b0, 16'h0002, 0};
        vecs[13] = '{4'b1111, 16'h0000, 16'h0001, 1'b0, 16'h0002, 3};

        RST = 1'b1; CMD_VALID = 1'b0; CMD_A = '0; CMD_B = '0; CMD_OP = '0;
        RES_READY = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_cmd_ready", CMD_READY, 1);
        check("rst_res_valid", RES_VALID, 0);
        check("rst_enables", enables(), 0);
        check("rst_a", A, 0);
        check("rst_b", B, 0);
        check("rst_fun", ALU_FUN, 0);
        check("rst_data", RES_DATA, 0);
        check("rst_unit", RES_UNIT, 0);
        check("rst_err", RES_ERR, 0);
        check("rst_count", OP_COUNT, 0);
        RST = 1'b0;

        // Reset during CAPTURE discards the in-flight command.
        CMD_OP = 4'b0101; CMD_A = 16'hABCD; CMD_B = 16'h1111; CMD_VALID = 1'b1;
        RES_READY = 1'b1;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        check("midrst_issue_en", Logic_Enable, 1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_cmd_ready", CMD_READY, 1);
        check("midrst_res_valid", RES_VALID, 0);
        check("midrst_enables", enables(), 0);
        check("midrst_data", RES_DATA, 0);
        check("midrst_count", OP_COUNT, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("midrst_no_result", RES_VALID, 0);
            check("midrst_count_hold", OP_COUNT, 0);
        end

        foreach (vecs[i])
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fl, vecs[i].exp_d,
                    vecs[i].hold, (vecs[i].hold == 0), 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [15:0] a, b;
            bit          fl;
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = 16'($urandom);
            fl = 1'($urandom_range(0, 1));
            run_cmd(op, a, b, fl, unit_fn(op[3:2], op[1:0], a, b),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Back-to-back OR commands with RES_READY high: count wraps to 0.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        exp_count = 0;
        check("wrap_start_count", OP_COUNT, 0);
        for (int i = 0; i < 256; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            run_cmd(4'b0101, a, b, 1'b1, a | b, 0, 1'b1, (i > 0));
        end
        check("wrap_final_count", OP_COUNT, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
